// File: rtl/hpi_if.sv
// Host-port bus between the Nios II otg_hpi_* PIOs and the HPI target.
// The host drives strobes, register select and write data; the target returns read data.
interface hpi_if;
    logic [1:0]  hpi_address;
    logic        hpi_cs_n;
    logic        hpi_r_n;
    logic        hpi_w_n;
    logic [15:0] hpi_data_in;
    logic [15:0] hpi_data_out;

    modport master (
        output hpi_address, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_in,
        input  hpi_data_out
    );

    modport slave (
        input  hpi_address, hpi_cs_n, hpi_r_n, hpi_w_n, hpi_data_in,
        output hpi_data_out
    );
endinterface

// File: rtl/hpi_target_model.sv
// EZ-OTG style host-port target: DATA/MAILBOX/ADDRESS/STATUS registers, word RAM
// behind an auto-incrementing byte pointer, and a two-way mailbox to fabric logic.
module hpi_target_model #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_clk,
    input  logic          reset_reset_n,
    hpi_if.slave          hpi,
    output logic          dev_mbx_valid,
    output logic [15:0]   dev_mbx_data,
    input  logic          dev_mbx_ack,
    input  logic          dev_mbx_wr,
    input  logic [15:0]   dev_mbx_wdata,
    input  logic [AW-1:0] dev_addr,
    input  logic          dev_we,
    input  logic [15:0]   dev_wdata,
    output logic [15:0]   dev_rdata
);

    typedef enum logic [1:0] {
        REG_DATA = 2'd0,
        REG_MBX  = 2'd1,
        REG_ADDR = 2'd2,
        REG_STAT = 2'd3
    } reg_sel_e;

    reg_sel_e    addr_q;
    logic        cs_n_q, r_n_q, w_n_q;
    logic [15:0] data_q;

    logic [15:0] ptr;
    logic [15:0] d2h;
    logic        d2h_full;
    logic [15:0] mem [DEPTH];

    logic          wr_commit, rd_commit, rd_sample;
    logic [AW-1:0] idx;
    logic [15:0]   rd_mux;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            addr_q <= REG_DATA;
            cs_n_q <= 1'b1;
            r_n_q  <= 1'b1;
            w_n_q  <= 1'b1;
            data_q <= '0;
        end else begin
            addr_q <= reg_sel_e'(hpi.hpi_address);
            cs_n_q <= hpi.hpi_cs_n;
            r_n_q  <= hpi.hpi_r_n;
            w_n_q  <= hpi.hpi_w_n;
            data_q <= hpi.hpi_data_in;
        end
    end

    // Commits fire on the rising strobe edge seen against the registered copy, so
    // each strobe commits once whatever its length; a read overlapped by a write is dropped.
    assign wr_commit = !w_n_q && hpi.hpi_w_n && !cs_n_q;
    assign rd_commit = !r_n_q && hpi.hpi_r_n && !cs_n_q && w_n_q;
    assign rd_sample = !cs_n_q && !r_n_q && w_n_q;
    assign idx       = ptr[AW:1];

    always_comb begin
        rd_mux = '0;
        case (addr_q)
            REG_DATA: rd_mux = mem[idx];
            REG_MBX:  rd_mux = d2h;
            REG_ADDR: rd_mux = ptr;
            REG_STAT: rd_mux = {14'b0, dev_mbx_valid, d2h_full};
            default:  rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            hpi.hpi_data_out <= '0;
        end else if (rd_sample) begin
            hpi.hpi_data_out <= rd_mux;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            ptr <= '0;
        end else if (wr_commit && addr_q == REG_ADDR) begin
            ptr <= data_q;
        end else if ((wr_commit || rd_commit) && addr_q == REG_DATA) begin
            ptr <= ptr + 16'd2;
        end
    end

    // Host write is ordered last so it wins a same-word collision with the fabric.
    always_ff @(posedge clk_clk) begin
        if (dev_we)
            mem[dev_addr] <= dev_wdata;
        if (wr_commit && addr_q == REG_DATA)
            mem[idx] <= data_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            dev_rdata <= '0;
        end else begin
            dev_rdata <= mem[dev_addr];
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            dev_mbx_valid <= 1'b0;
            dev_mbx_data  <= '0;
        end else if (wr_commit && addr_q == REG_MBX) begin
            dev_mbx_valid <= 1'b1;
            dev_mbx_data  <= data_q;
        end else if (dev_mbx_ack) begin
            dev_mbx_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            d2h      <= '0;
            d2h_full <= 1'b0;
        end else if (dev_mbx_wr) begin
            d2h      <= dev_mbx_wdata;
            d2h_full <= 1'b1;
        end else if (rd_commit && addr_q == REG_MBX) begin
            d2h_full <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hpi_target_model.sv
// Directed bench for hpi_target_model: expected values are queued when a step is
// issued and compared when the DUT output is sampled.
module tb_hpi_target_model;
    localparam int AW = 10;
    localparam logic [1:0] R_DATA = 2'd0, R_MBX = 2'd1, R_ADDR = 2'd2, R_STAT = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          dev_mbx_valid, dev_mbx_ack, dev_mbx_wr, dev_we;
    logic [15:0]   dev_mbx_data, dev_mbx_wdata, dev_wdata, dev_rdata;
    logic [AW-1:0] dev_addr;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    hpi_if hif();

    hpi_target_model #(.DEPTH(1024), .AW(AW)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .hpi           (hif),
        .dev_mbx_valid (dev_mbx_valid),
        .dev_mbx_data  (dev_mbx_data),
        .dev_mbx_ack   (dev_mbx_ack),
        .dev_mbx_wr    (dev_mbx_wr),
        .dev_mbx_wdata (dev_mbx_wdata),
        .dev_addr      (dev_addr),
        .dev_we        (dev_we),
        .dev_wdata     (dev_wdata),
        .dev_rdata     (dev_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs);
        logic [15:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed %h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s observed %h expected %h", tag, obs, e);
            end
        end
    endtask

    task automatic hwr(input logic [1:0] a, input logic [15:0] d,
                       input bit ack, input bit we, input logic [AW-1:0] wa, input logic [15:0] wd);
        @(negedge clk);
        hif.hpi_address = a; hif.hpi_data_in = d;
        hif.hpi_cs_n = 1'b0; hif.hpi_w_n = 1'b0;
        @(negedge clk);
        hif.hpi_w_n = 1'b1; hif.hpi_cs_n = 1'b1;
        if (ack) dev_mbx_ack = 1'b1;
        if (we) begin dev_we = 1'b1; dev_addr = wa; dev_wdata = wd; end
        @(negedge clk);
        dev_mbx_ack = 1'b0; dev_we = 1'b0;
    endtask

    task automatic hrd(input logic [1:0] a, input int width, input logic [15:0] e, input string tag);
        exp_q.push_back(e);
        @(negedge clk);
        hif.hpi_address = a; hif.hpi_cs_n = 1'b0; hif.hpi_r_n = 1'b0;
        repeat (width) @(negedge clk);
        hif.hpi_r_n = 1'b1; hif.hpi_cs_n = 1'b1;
        @(negedge clk);
        chk(tag, hif.hpi_data_out);
    endtask

    task automatic drd(input logic [AW-1:0] a, input logic [15:0] e, input string tag);
        exp_q.push_back(e);
        @(negedge clk);
        dev_addr = a;
        @(negedge clk);
        chk(tag, dev_rdata);
    endtask

    task automatic sig(input logic [15:0] obs, input logic [15:0] e, input string tag);
        exp_q.push_back(e);
        chk(tag, obs);
    endtask

    initial begin
        rst_n = 1'b0;
        hif.hpi_address = R_DATA; hif.hpi_cs_n = 1'b1; hif.hpi_r_n = 1'b1;
        hif.hpi_w_n = 1'b1; hif.hpi_data_in = '0;
        dev_mbx_ack = 1'b0; dev_mbx_wr = 1'b0; dev_mbx_wdata = '0;
        dev_addr = '0; dev_we = 1'b0; dev_wdata = '0;
        repeat (3) @(negedge clk);
        sig(hif.hpi_data_out, 16'h0000, "rst_data_out");
        sig({15'b0, dev_mbx_valid}, 16'h0000, "rst_mbx_valid");
        sig(dev_mbx_data, 16'h0000, "rst_mbx_data");
        sig(dev_rdata, 16'h0000, "rst_dev_rdata");
        rst_n = 1'b1;

        // pointer + DATA writes
        hwr(R_ADDR, 16'h0010, 0, 0, '0, '0);
        hwr(R_DATA, 16'hBEEF, 0, 0, '0, '0);
        hwr(R_DATA, 16'hCAFE, 0, 0, '0, '0);
        hrd(R_ADDR, 1, 16'h0014, "ptr_after_wr");
        drd(10'd8, 16'hBEEF, "dev_rd_8");
        drd(10'd9, 16'hCAFE, "dev_rd_9");

        // auto-increment reads, second with a long strobe
        hwr(R_ADDR, 16'h0010, 0, 0, '0, '0);
        hrd(R_DATA, 1, 16'hBEEF, "data_rd0");
        hrd(R_DATA, 20, 16'hCAFE, "data_rd1_long");
        hrd(R_ADDR, 1, 16'h0014, "ptr_after_rd");

        // wrap and alias
        hwr(R_ADDR, 16'hFFFE, 0, 0, '0, '0);
        hwr(R_DATA, 16'h1234, 0, 0, '0, '0);
        hrd(R_ADDR, 1, 16'h0000, "ptr_wrap");
        drd(10'd1023, 16'h1234, "dev_rd_1023");
        hwr(R_ADDR, 16'h07FE, 0, 0, '0, '0);
        hrd(R_DATA, 1, 16'h1234, "alias_rd");

        // mailboxes
        hwr(R_MBX, 16'h00A5, 0, 0, '0, '0);
        sig({15'b0, dev_mbx_valid}, 16'h0001, "h2d_valid");
        sig(dev_mbx_data, 16'h00A5, "h2d_data");
        hrd(R_STAT, 1, 16'h0002, "stat_h2d");
        @(negedge clk); dev_mbx_ack = 1'b1;
        @(negedge clk); dev_mbx_ack = 1'b0;
        hrd(R_STAT, 1, 16'h0000, "stat_acked");
        @(negedge clk); dev_mbx_wr = 1'b1; dev_mbx_wdata = 16'h5A5A;
        @(negedge clk); dev_mbx_wr = 1'b0;
        hrd(R_STAT, 1, 16'h0001, "stat_d2h");
        hrd(R_MBX, 1, 16'h5A5A, "d2h_rd");
        hrd(R_STAT, 1, 16'h0000, "stat_d2h_clr");

        // collisions
        hwr(R_MBX, 16'h0077, 1, 0, '0, '0);
        sig({15'b0, dev_mbx_valid}, 16'h0001, "coll_valid");
        sig(dev_mbx_data, 16'h0077, "coll_mbx_data");
        hwr(R_ADDR, 16'h0020, 0, 0, '0, '0);
        hwr(R_DATA, 16'h1111, 0, 1, 10'd16, 16'h2222);
        drd(10'd16, 16'h1111, "coll_ram");

        // read and write strobes overlapping
        hwr(R_ADDR, 16'h0030, 0, 0, '0, '0);
        hrd(R_ADDR, 1, 16'h0030, "ptr_30");
        @(negedge clk);
        hif.hpi_address = R_DATA; hif.hpi_data_in = 16'h4444;
        hif.hpi_cs_n = 1'b0; hif.hpi_r_n = 1'b0; hif.hpi_w_n = 1'b0;
        @(negedge clk);
        hif.hpi_r_n = 1'b1; hif.hpi_w_n = 1'b1; hif.hpi_cs_n = 1'b1;
        @(negedge clk);
        sig(hif.hpi_data_out, 16'h0030, "illegal_hold");
        hrd(R_ADDR, 1, 16'h0032, "illegal_ptr");
        drd(10'd24, 16'h4444, "illegal_ram");

        // reset in the middle of a DATA write strobe
        hwr(R_ADDR, 16'h0040, 0, 0, '0, '0);
        @(negedge clk); dev_we = 1'b1; dev_addr = 10'd32; dev_wdata = 16'h9999;
        @(negedge clk); dev_we = 1'b0;
        @(negedge clk);
        hif.hpi_address = R_DATA; hif.hpi_data_in = 16'h5555;
        hif.hpi_cs_n = 1'b0; hif.hpi_w_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b0;
        @(negedge clk);
        sig(hif.hpi_data_out, 16'h0000, "mid_rst_data_out");
        sig({15'b0, dev_mbx_valid}, 16'h0000, "mid_rst_valid");
        sig(dev_mbx_data, 16'h0000, "mid_rst_mbx_data");
        sig(dev_rdata, 16'h0000, "mid_rst_dev_rdata");
        #1 hif.hpi_w_n = 1'b1; hif.hpi_cs_n = 1'b1;
        @(negedge clk); rst_n = 1'b1;
        hrd(R_ADDR, 1, 16'h0000, "post_rst_ptr");
        hrd(R_STAT, 1, 16'h0000, "post_rst_stat");
        drd(10'd32, 16'h9999, "post_rst_ram");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
